// File: rtl/gcd_controller.sv
// Control FSM for the GCD subtract-and-compare datapath: load, subtract until equal, hold done.
// Optional macro GCD_TIMEOUT_EN aborts with err after MAX_ITER subtract steps.
module gcd_controller #(
    parameter int CNT_W = 32
`ifdef GCD_TIMEOUT_EN
    , parameter logic [CNT_W-1:0] MAX_ITER = {CNT_W{1'b1}}
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             done_ack,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic             a_sel,
    output logic             b_sel,
    output logic             a_ld,
    output logic             b_ld,
    output logic             output_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, CMP, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Step counter saturates rather than wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef GCD_TIMEOUT_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        output_en = 1'b0;
`ifdef GCD_TIMEOUT_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_ld    = 1'b1;
                b_ld    = 1'b1;
                state_d = CMP;
            end
            CMP: begin
                if (a_eq_b) begin
                    output_en = 1'b1;
                    state_d   = DONE;
                end
`ifdef GCD_TIMEOUT_EN
                else if (cnt_q == MAX_ITER) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
                else if (a_gt_b) begin
                    a_sel = 1'b0;
                    a_ld  = 1'b1;
                    cnt_d = cnt_inc;
                end else if (a_lt_b) begin
                    b_sel = 1'b0;
                    b_ld  = 1'b1;
                    cnt_d = cnt_inc;
                end else begin
                    // No comparator flag is illegal; finish as if equal.
                    output_en = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (done_ack) begin
                    state_d = IDLE;
`ifdef GCD_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef GCD_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef GCD_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy     = (state_q == LOAD) || (state_q == CMP);
    assign done     = (state_q == DONE);
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller with a behavioural subtract/compare datapath around it.
module tb_gcd_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, done_ack;
    logic        a_gt_b, a_eq_b, a_lt_b;
    logic        a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err;
    logic [31:0] step_cnt;
    logic [31:0] in1, in2, ra, rb, rout;
    logic [6:0]  ctl;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    gcd_controller #(
        .CNT_W(32)
`ifdef GCD_TIMEOUT_EN
        , .MAX_ITER(32'd8)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .done_ack(done_ack),
        .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
        .a_sel(a_sel), .b_sel(b_sel), .a_ld(a_ld), .b_ld(b_ld),
        .output_en(output_en), .busy(busy), .done(done), .err(err),
        .step_cnt(step_cnt)
    );

    // Datapath environment: operand registers, subtractors, comparator, output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra <= '0; rb <= '0; rout <= '0;
        end else begin
            if (a_ld) ra <= a_sel ? in1 : ra - rb;
            if (b_ld) rb <= b_sel ? in2 : rb - ra;
            if (output_en) rout <= ra;
        end
    end
    assign a_gt_b = ra > rb;
    assign a_eq_b = ra == rb;
    assign a_lt_b = ra < rb;

    // {a_sel, b_sel, a_ld, b_ld, output_en, busy, done}
    assign ctl = {a_sel, b_sel, a_ld, b_ld, output_en, busy, done};

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; done_ack = 1'b0; in1 = '0; in2 = '0;
        #3;
        n_chk++; if (ctl !== 7'b1100000 || err !== 1'b0) begin n_fail++;
            $display("FAIL reset_ctl: got %b/%b want 1100000/0", ctl, err); end
        n_chk++; if (step_cnt !== 32'd0) begin n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", step_cnt); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset_mid_cmp;
        @(negedge clk); in1 = 32'd100; in2 = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (ctl !== 7'b0110010) begin n_fail++;
            $display("FAIL midcmp_pre: got %b want 0110010", ctl); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (ctl !== 7'b1100000 || step_cnt !== 32'd0) begin n_fail++;
            $display("FAIL midcmp_reset: got %b cnt %0d want 1100000 cnt 0", ctl, step_cnt); end
        #1 rst = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== 7'b1100000) begin n_fail++;
            $display("FAIL midcmp_idle: got %b want 1100000", ctl); end
    endtask

    task automatic test_equal;
        in1 = 32'd18; in2 = 32'd18; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_chk++; if (ctl !== 7'b1111010) begin n_fail++;
            $display("FAIL eq_load: got %b want 1111010", ctl); end
        @(negedge clk);
        n_chk++; if (ctl !== 7'b1100110) begin n_fail++;
            $display("FAIL eq_cmp: got %b want 1100110", ctl); end
        @(negedge clk);
        n_chk++; if (ctl !== 7'b1100001 || step_cnt !== 32'd0 || rout !== 32'd18) begin n_fail++;
            $display("FAIL eq_done: got %b cnt %0d out %0d want 1100001 cnt 0 out 18", ctl, step_cnt, rout); end
        done_ack = 1'b1;
        @(negedge clk); done_ack = 1'b0;
        n_chk++; if (ctl !== 7'b1100000) begin n_fail++;
            $display("FAIL eq_ack: got %b want 1100000", ctl); end
    endtask

    task automatic test_12_18;
        in1 = 32'd12; in2 = 32'd18; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_chk++; if (ctl !== 7'b1111010) begin n_fail++;
            $display("FAIL s12_load: got %b want 1111010", ctl); end
        @(negedge clk);
        n_chk++; if (ctl !== 7'b1001010) begin n_fail++;
            $display("FAIL s12_bsub: got %b want 1001010", ctl); end
        @(negedge clk);
        n_chk++; if (ctl !== 7'b0110010 || rb !== 32'd6) begin n_fail++;
            $display("FAIL s12_asub: got %b B %0d want 0110010 B 6", ctl, rb); end
        @(negedge clk);
        n_chk++; if (ctl !== 7'b1100110) begin n_fail++;
            $display("FAIL s12_eq: got %b want 1100110", ctl); end
        @(negedge clk);
        n_chk++; if (ctl !== 7'b1100001 || step_cnt !== 32'd2 || rout !== 32'd6) begin n_fail++;
            $display("FAIL s12_done: got %b cnt %0d out %0d want 1100001 cnt 2 out 6", ctl, step_cnt, rout); end
        done_ack = 1'b1;
        @(negedge clk); done_ack = 1'b0;
    endtask

    task automatic test_35_14;
        bit ok;
        in1 = 32'd35; in2 = 32'd14; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(50, ok);
        n_chk++; if (!ok) begin n_fail++;
            $display("FAIL s35_timeout: done %b want 1 within 50 cycles", done); end
        n_chk++; if (step_cnt !== 32'd3 || rout !== 32'd7) begin n_fail++;
            $display("FAIL s35_result: cnt %0d out %0d want cnt 3 out 7", step_cnt, rout); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (ctl !== 7'b1100001) begin n_fail++;
                $display("FAIL s35_hold%0d: got %b want 1100001", i, ctl); end
        end
        done_ack = 1'b1;
        @(negedge clk); done_ack = 1'b0;
        n_chk++; if (ctl !== 7'b1100000) begin n_fail++;
            $display("FAIL s35_ack: got %b want 1100000", ctl); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        in1 = 32'd8; in2 = 32'd12; start = 1'b1;
        wait_done(50, ok);
        n_chk++; if (!ok || rout !== 32'd4 || step_cnt !== 32'd2) begin n_fail++;
            $display("FAIL b2b_first: done %b out %0d cnt %0d want 1 out 4 cnt 2", done, rout, step_cnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (ctl !== 7'b1100001) begin n_fail++;
                $display("FAIL b2b_noload%0d: got %b want 1100001", i, ctl); end
        end
        in1 = 32'd9; in2 = 32'd6; done_ack = 1'b1;
        @(negedge clk); done_ack = 1'b0;
        n_chk++; if (ctl !== 7'b1100000) begin n_fail++;
            $display("FAIL b2b_idle: got %b want 1100000", ctl); end
        @(negedge clk);
        n_chk++; if (ctl !== 7'b1111010) begin n_fail++;
            $display("FAIL b2b_load: got %b want 1111010", ctl); end
        wait_done(50, ok);
        n_chk++; if (!ok || rout !== 32'd3 || step_cnt !== 32'd2) begin n_fail++;
            $display("FAIL b2b_second: done %b out %0d cnt %0d want 1 out 3 cnt 2", done, rout, step_cnt); end
        start = 1'b0; done_ack = 1'b1;
        @(negedge clk); done_ack = 1'b0;
    endtask

`ifdef GCD_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        in1 = 32'd0; in2 = 32'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(40, ok);
        n_chk++; if (!ok || err !== 1'b1 || step_cnt !== 32'd8) begin n_fail++;
            $display("FAIL to_abort: done %b err %b cnt %0d want 1 1 8", done, err, step_cnt); end
        n_chk++; if (rout !== 32'd3) begin n_fail++;
            $display("FAIL to_out: got %0d want 3", rout); end
        done_ack = 1'b1;
        @(negedge clk); done_ack = 1'b0;
        n_chk++; if (err !== 1'b0 || done !== 1'b0) begin n_fail++;
            $display("FAIL to_ack: err %b done %b want 0 0", err, done); end
    endtask
`endif

    initial begin
        test_reset;
        test_reset_mid_cmp;
        test_equal;
        test_12_18;
        test_35_14;
        test_back_to_back;
`ifdef GCD_TIMEOUT_EN
        test_timeout;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
